// File: rtl/load_store_unit.sv
// load_store_unit: memory-access stage between the ALU and a single-port
// data memory. Runs one req/ack transaction per load or store, steers
// store bytes onto the correct lanes, extends load data, and flags
// misaligned or illegal accesses without issuing a memory request.
module load_store_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 9
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  MemRead,
    input  logic                  MemWrite,
    input  logic [2:0]            Funct3,
    input  logic [DATA_WIDTH-1:0] ALUResult,
    input  logic [DATA_WIDTH-1:0] StoreData,
    output logic                  Stall,
    output logic [DATA_WIDTH-1:0] LoadData,
    output logic                  LoadValid,
    output logic                  Fault,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [3:0]            mem_be,
    input  logic                  mem_ack,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;

    // Latched copy of the accepted access, needed to extend the load result
    logic [2:0] lat_funct3;
    logic [1:0] lat_offset;
    logic       lat_load;

    // Decode of the incoming access
    logic                  access;
    logic                  is_store;
    logic                  funct3_legal;
    logic                  misaligned;
    logic                  accept;
    logic                  fault_detect;
    logic [3:0]            req_be;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic [DATA_WIDTH-1:0] load_ext;
    logic [7:0]            byte_lane;
    logic [15:0]           half_lane;

    // Address bits above the word address are intentionally ignored
    logic unused_addr_bits;
    assign unused_addr_bits = ^ALUResult[DATA_WIDTH-1:ADDR_WIDTH+2];

    // Classify the current access: legality, alignment and store lane steering
    always_comb begin
        access       = MemRead | MemWrite;
        is_store     = MemWrite;
        funct3_legal = 1'b0;
        misaligned   = 1'b0;
        req_be       = 4'b1111;
        req_wdata    = '0;

        case (Funct3)
            3'b000, 3'b001, 3'b010: funct3_legal = 1'b1;
            3'b100, 3'b101:         funct3_legal = ~is_store;
            default:                funct3_legal = 1'b0;
        endcase

        case (Funct3[1:0])
            2'b01:   misaligned = ALUResult[0];
            2'b10:   misaligned = (ALUResult[1:0] != 2'b00);
            default: misaligned = 1'b0;
        endcase

        if (is_store) begin
            case (Funct3[1:0])
                2'b00: begin
                    req_be    = 4'b0001 << ALUResult[1:0];
                    req_wdata = {4{StoreData[7:0]}};
                end
                2'b01: begin
                    req_be    = ALUResult[1] ? 4'b1100 : 4'b0011;
                    req_wdata = {2{StoreData[15:0]}};
                end
                default: begin
                    req_be    = 4'b1111;
                    req_wdata = StoreData;
                end
            endcase
        end

        accept       = access & funct3_legal & ~misaligned;
        fault_detect = access & ~(funct3_legal & ~misaligned);
    end

    // Pick the addressed lane out of the returned word and extend it
    always_comb begin
        case (lat_offset)
            2'd0:    byte_lane = mem_rdata[7:0];
            2'd1:    byte_lane = mem_rdata[15:8];
            2'd2:    byte_lane = mem_rdata[23:16];
            default: byte_lane = mem_rdata[31:24];
        endcase
        half_lane = lat_offset[1] ? mem_rdata[31:16] : mem_rdata[15:0];

        case (lat_funct3)
            3'b000:  load_ext = {{(DATA_WIDTH-8){byte_lane[7]}}, byte_lane};
            3'b001:  load_ext = {{(DATA_WIDTH-16){half_lane[15]}}, half_lane};
            3'b100:  load_ext = {{(DATA_WIDTH-8){1'b0}}, byte_lane};
            3'b101:  load_ext = {{(DATA_WIDTH-16){1'b0}}, half_lane};
            default: load_ext = mem_rdata;
        endcase
    end

    // Stall is gated by reset so every output reads 0 while reset is held,
    // even if the pipeline is still presenting an access
    assign Stall = reset & (((state == IDLE) & accept) | (state == BUSY));

    // Transaction FSM with registered memory request and status outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_be     <= 4'b0000;
            LoadData   <= '0;
            LoadValid  <= 1'b0;
            Fault      <= 1'b0;
            lat_funct3 <= 3'b000;
            lat_offset <= 2'b00;
            lat_load   <= 1'b0;
        end else begin
            Fault     <= 1'b0;
            LoadValid <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        state      <= BUSY;
                        mem_req    <= 1'b1;
                        mem_we     <= is_store;
                        mem_addr   <= ALUResult[ADDR_WIDTH+1:2];
                        mem_wdata  <= req_wdata;
                        mem_be     <= req_be;
                        lat_funct3 <= Funct3;
                        lat_offset <= ALUResult[1:0];
                        lat_load   <= ~is_store;
                    end else if (fault_detect) begin
                        Fault <= 1'b1;
                    end
                end
                BUSY: begin
                    if (mem_ack) begin
                        state     <= DONE;
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        LoadValid <= lat_load;
                        if (lat_load) begin
                            LoadData <= load_ext;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed testbench for load_store_unit: stores, loads with extension,
// faults, delayed acknowledge and reset in the middle of a transaction.
module tb_load_store_unit;

    logic        clk;
    logic        reset;
    logic        MemRead;
    logic        MemWrite;
    logic [2:0]  Funct3;
    logic [31:0] ALUResult;
    logic [31:0] StoreData;
    logic        Stall;
    logic [31:0] LoadData;
    logic        LoadValid;
    logic        Fault;
    logic        mem_req;
    logic        mem_we;
    logic [8:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int n_asserts;
    int n_fail;

    load_store_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(9)) dut (
        .clk       (clk),
        .reset     (reset),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .Funct3    (Funct3),
        .ALUResult (ALUResult),
        .StoreData (StoreData),
        .Stall     (Stall),
        .LoadData  (LoadData),
        .LoadValid (LoadValid),
        .Fault     (Fault),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_be    (mem_be),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
    );

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against a hand-computed expectation
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        n_asserts++;
        assert (observed === expected) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Advance one cycle; inputs change and outputs are sampled on the falling edge
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Present an access to the unit
    task automatic applyStimulus(input logic rd, input logic wr, input logic [2:0] f3,
                                 input logic [31:0] addr, input logic [31:0] sdata);
        MemRead   = rd;
        MemWrite  = wr;
        Funct3    = f3;
        ALUResult = addr;
        StoreData = sdata;
    endtask

    // Remove the access once the pipeline advances
    task automatic clearStimulus();
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        Funct3   = 3'b000;
        mem_ack  = 1'b0;
    endtask

    // Load with immediate acknowledge and check the extended result
    task automatic doLoad(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] rdata, input logic [31:0] expected);
        applyStimulus(1'b1, 1'b0, f3, addr, 32'h0);
        mem_ack   = 1'b1;
        mem_rdata = rdata;
        #1;
        checkOutput({tag, " stall T"}, {31'd0, Stall}, 32'd1);
        tick();
        checkOutput({tag, " req T+1"}, {31'd0, mem_req}, 32'd1);
        checkOutput({tag, " we T+1"}, {31'd0, mem_we}, 32'd0);
        checkOutput({tag, " be T+1"}, {28'd0, mem_be}, 32'hF);
        checkOutput({tag, " addr T+1"}, {23'd0, mem_addr}, {23'd0, addr[10:2]});
        tick();
        checkOutput({tag, " valid T+2"}, {31'd0, LoadValid}, 32'd1);
        checkOutput({tag, " data T+2"}, LoadData, expected);
        checkOutput({tag, " stall T+2"}, {31'd0, Stall}, 32'd0);
        checkOutput({tag, " req T+2"}, {31'd0, mem_req}, 32'd0);
        clearStimulus();
        tick();
        checkOutput({tag, " valid T+3"}, {31'd0, LoadValid}, 32'd0);
        checkOutput({tag, " data held"}, LoadData, expected);
    endtask

    // Illegal or misaligned access: fault pulse, no request, no stall
    task automatic doFault(input string tag, input logic rd, input logic wr,
                           input logic [2:0] f3, input logic [31:0] addr);
        applyStimulus(rd, wr, f3, addr, 32'h5555AAAA);
        #1;
        checkOutput({tag, " stall"}, {31'd0, Stall}, 32'd0);
        checkOutput({tag, " no early fault"}, {31'd0, Fault}, 32'd0);
        tick();
        clearStimulus();
        #1;
        checkOutput({tag, " fault pulse"}, {31'd0, Fault}, 32'd1);
        checkOutput({tag, " no req"}, {31'd0, mem_req}, 32'd0);
        checkOutput({tag, " stall after"}, {31'd0, Stall}, 32'd0);
        tick();
        checkOutput({tag, " fault ends"}, {31'd0, Fault}, 32'd0);
        checkOutput({tag, " no req later"}, {31'd0, mem_req}, 32'd0);
    endtask

    // Directed sequence of steps
    initial begin
        n_asserts = 0;
        n_fail    = 0;
        reset     = 1'b0;
        MemRead   = 1'b1;
        MemWrite  = 1'b0;
        Funct3    = 3'b010;
        ALUResult = 32'h0;
        StoreData = 32'h0;
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;

        // Reset values, with a legal access present that must not raise Stall
        tick();
        checkOutput("reset stall", {31'd0, Stall}, 32'd0);
        checkOutput("reset req", {31'd0, mem_req}, 32'd0);
        checkOutput("reset we", {31'd0, mem_we}, 32'd0);
        checkOutput("reset addr", {23'd0, mem_addr}, 32'd0);
        checkOutput("reset be", {28'd0, mem_be}, 32'd0);
        checkOutput("reset wdata", mem_wdata, 32'd0);
        checkOutput("reset loaddata", LoadData, 32'd0);
        checkOutput("reset valid", {31'd0, LoadValid}, 32'd0);
        checkOutput("reset fault", {31'd0, Fault}, 32'd0);
        clearStimulus();
        reset = 1'b1;
        tick();

        // SW 0xDEADBEEF at 0x10 with immediate ack
        applyStimulus(1'b0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
        mem_ack = 1'b1;
        #1;
        checkOutput("sw stall T", {31'd0, Stall}, 32'd1);
        tick();
        checkOutput("sw req", {31'd0, mem_req}, 32'd1);
        checkOutput("sw we", {31'd0, mem_we}, 32'd1);
        checkOutput("sw addr", {23'd0, mem_addr}, 32'd4);
        checkOutput("sw be", {28'd0, mem_be}, 32'hF);
        checkOutput("sw wdata", mem_wdata, 32'hDEADBEEF);
        checkOutput("sw stall T+1", {31'd0, Stall}, 32'd1);
        tick();
        checkOutput("sw stall T+2", {31'd0, Stall}, 32'd0);
        checkOutput("sw req done", {31'd0, mem_req}, 32'd0);
        checkOutput("sw no valid", {31'd0, LoadValid}, 32'd0);
        clearStimulus();
        tick();
        checkOutput("sw no valid after", {31'd0, LoadValid}, 32'd0);

        // SH 0x1234ABCD at 0x06 lands in the upper halfword of word 1
        applyStimulus(1'b0, 1'b1, 3'b001, 32'h06, 32'h1234ABCD);
        mem_ack = 1'b1;
        tick();
        checkOutput("sh addr", {23'd0, mem_addr}, 32'd1);
        checkOutput("sh be", {28'd0, mem_be}, 32'hC);
        checkOutput("sh wdata", mem_wdata, 32'hABCDABCD);
        checkOutput("sh we", {31'd0, mem_we}, 32'd1);
        tick();
        clearStimulus();
        tick();

        // SB 0x000000A5 at 0x0D: lane 1, byte replicated
        applyStimulus(1'b0, 1'b1, 3'b000, 32'h0D, 32'h000000A5);
        mem_ack = 1'b1;
        tick();
        checkOutput("sb addr", {23'd0, mem_addr}, 32'd3);
        checkOutput("sb be", {28'd0, mem_be}, 32'h2);
        checkOutput("sb wdata", mem_wdata, 32'hA5A5A5A5);
        tick();
        clearStimulus();
        tick();

        // Loads with sign and zero extension
        doLoad("lb", 3'b000, 32'h13, 32'h80FF1234, 32'hFFFFFF80);
        doLoad("lbu", 3'b100, 32'h13, 32'h80FF1234, 32'h00000080);
        doLoad("lh", 3'b001, 32'h12, 32'h80FF1234, 32'hFFFF80FF);
        doLoad("lhu", 3'b101, 32'h12, 32'h80FF1234, 32'h000080FF);
        doLoad("lb pos", 3'b000, 32'h11, 32'h80FF1234, 32'h00000012);
        doLoad("lw", 3'b010, 32'h7FC, 32'h80FF1234, 32'h80FF1234);

        // Faults: misaligned word, illegal load funct3, misaligned half store, illegal store funct3
        doFault("lw misaligned", 1'b1, 1'b0, 3'b010, 32'h02);
        doFault("load f3 011", 1'b1, 1'b0, 3'b011, 32'h00);
        doFault("sh misaligned", 1'b0, 1'b1, 3'b001, 32'h01);
        doFault("store f3 100", 1'b0, 1'b1, 3'b100, 32'h00);

        // LW at 0x20 with ack delayed by three cycles
        applyStimulus(1'b1, 1'b0, 3'b010, 32'h20, 32'h0);
        mem_ack   = 1'b0;
        mem_rdata = 32'h11111111;
        #1;
        checkOutput("delay stall T", {31'd0, Stall}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            checkOutput("delay req", {31'd0, mem_req}, 32'd1);
            checkOutput("delay addr", {23'd0, mem_addr}, 32'd8);
            checkOutput("delay be", {28'd0, mem_be}, 32'hF);
            checkOutput("delay stall", {31'd0, Stall}, 32'd1);
            checkOutput("delay no valid", {31'd0, LoadValid}, 32'd0);
            if (i == 3) begin
                mem_ack   = 1'b1;
                mem_rdata = 32'hCAFEF00D;
            end
        end
        tick();
        checkOutput("delay stall done", {31'd0, Stall}, 32'd0);
        checkOutput("delay valid", {31'd0, LoadValid}, 32'd1);
        checkOutput("delay data", LoadData, 32'hCAFEF00D);
        clearStimulus();
        tick();

        // Reset asserted in the middle of BUSY
        applyStimulus(1'b1, 1'b0, 3'b010, 32'h04, 32'h0);
        mem_ack = 1'b0;
        tick();
        checkOutput("rst busy req", {31'd0, mem_req}, 32'd1);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("rst req drop", {31'd0, mem_req}, 32'd0);
        checkOutput("rst stall drop", {31'd0, Stall}, 32'd0);
        checkOutput("rst valid", {31'd0, LoadValid}, 32'd0);
        checkOutput("rst loaddata", LoadData, 32'd0);
        clearStimulus();
        tick();
        reset = 1'b1;
        tick();
        checkOutput("rst idle req", {31'd0, mem_req}, 32'd0);

        // Next load after reset completes normally
        doLoad("post rst lhu", 3'b101, 32'h06, 32'h8001BEEF, 32'h00008001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
